rr_mux8_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for the 8-to-1 multiplexer datapath built from three levels of 2-to-1 muxes.
- Eight requesters share the single mux output. The block grants one requester at a time and drives the 3-bit select (s2,s1,s0 packed as sel[2:0]).
- It holds a grant for at most MAX_BURST cycles, then rotates priority.
- It also presents the selected data on y, qualified by valid.

---
 rtl/rr_mux8_arbiter.sv | 117 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter and select sequencer for an 8-to-1 mux datapath.
// Grants one requester for up to MAX_BURST cycles, then rotates priority past it.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no grant; next edge searches req from ptr upward (wrapping 7->0)
// GRANT | requester sel owns the mux; cnt counts held cycles after the first
module rr_mux8_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] d,
  output logic [7:0]     gnt,
  output logic [2:0]     sel,
  output logic           valid,
  output logic [W-1:0]   y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  // Walk offsets from the far end down so the smallest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win_idx;
          sel_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q] || (cnt_q == CNT_LAST)) begin
          // sel is left at the last owner; only the pointer advances.
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  // Data path is unregistered so y follows d within the cycle.
  always_comb begin
    y = '0;
    if (valid_q) y = d[sel_q*W +: W];
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench for rr_mux8_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level ownership model (owner, cycles used, rotation pointer).
`timescale 1ns/1ps

module tb_rr_mux8_arbiter;

  localparam int W  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     req = '0;
  logic [8*W-1:0] d = '0;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           valid;
  logic [W-1:0]   y;

  rr_mux8_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  // Model: owner = granted index or -1, used = valid cycles so far in this burst.
  int m_owner = -1;
  int m_used  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_y();
    if (m_owner < 0) return '0;
    return d[m_owner*W +: W];
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_owner = -1; m_used = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (w >= 0) begin
        m_owner = w; m_used = 1; m_sel = w;
      end
    end else if (!req[m_owner] || m_used == MB) begin
      m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
      m_used++;
    end
  endtask

  task automatic check_all();
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    chk("gnt",   32'(gnt),   eg);
    chk("sel",   32'(sel),   32'(m_sel));
    chk("valid", 32'(valid), (m_owner >= 0) ? 32'h1 : 32'h0);
    chk("y",     32'(y),     32'(exp_y()));
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq);
    rst_n = r;
    req   = rq;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int order[$];
    int vcnt;
    logic prev_v;
    logic [8*W-1:0] d_save;
    logic [7:0] rq;

    // Reset out of X with everyone requesting.
    phase = "reset";
    cyc(1'b0, 8'hFF);
    cyc(1'b0, 8'hFF);

    // Full rotation; channel 0 carries 1, all others 0.
    phase = "rotate";
    d = '0;
    d[0 +: W] = 4'h1;
    prev_v = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cyc(1'b1, 8'hFF);
      if (i == 0) chk("first_gnt", 32'(gnt), 32'h01);
      if (valid && !prev_v) order.push_back(int'(sel));
      prev_v = valid;
    end
    chk("grant_count", 32'(order.size()), 32'd9);
    for (int i = 0; i < order.size() && i < 9; i++)
      chk("order", 32'(order[i]), 32'(i % 8));

    // Lone requester 3: 4 valid, 1 bubble, repeat.
    phase = "lone";
    cyc(1'b0, 8'h00);
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 8'h08);
      if (valid) vcnt++;
    end
    chk("valid_cycles", 32'(vcnt), 32'd12);

    // Move ptr to 7, then early release of 7 must wrap to 0.
    phase = "wrap";
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h40);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h81);
    chk("gnt7", 32'(gnt), 32'h80);
    cyc(1'b1, 8'h81);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h01);
    chk("gnt0_after_wrap", 32'(gnt), 32'h01);

    // Reset in the middle of requester 5's burst.
    phase = "midreset";
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h20);
    cyc(1'b1, 8'h20);
    cyc(1'b1, 8'h20);
    cyc(1'b0, 8'h20);
    chk("gnt_dropped", 32'(gnt), 32'h00);
    cyc(1'b1, 8'h21);
    chk("gnt_after_reset", 32'(gnt), 32'h01);

    // Data select with d[i]=i+1, plus same-cycle d changes.
    phase = "data";
    for (int i = 0; i < 8; i++) d[i*W +: W] = 4'(i + 1);
    cyc(1'b0, 8'h00);
    for (int i = 0; i < 42; i++) begin
      cyc(1'b1, 8'hFF);
      if (valid) chk("y_sel_plus1", 32'(y), 32'(sel) + 32'd1);
      if (valid && (i % 7 == 3)) begin
        d_save = d;
        d[int'(sel)*W +: W] = ~d[int'(sel)*W +: W];
        #1;
        chk("y_follows_d", 32'(y), 32'(exp_y()));
        d = d_save;
        #1;
      end
    end

    // Random traffic with occasional resets.
    phase = "random";
    rq = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      if ($urandom_range(0, 1) == 0) d = $urandom;
      cyc($urandom_range(0, 63) != 0, rq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
